// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles little-endian bytes into a 32-bit word. o_word
//                already contains the byte offered this cycle so the word is
//                complete in the same cycle the last byte is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic [31:0] o_word
);

    localparam int c_idx_w = $clog2(WORD_BYTES);

    logic [c_idx_w-1:0] r_idx;
    logic [31:0]        r_asm;

    // Byte index and assembly register; index wraps back to 0 after the last byte
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (i_accept) begin
            r_asm[8*r_idx +: 8] <= i_byte;
            r_idx               <= r_idx + 1'b1;
        end
    end

    // Current word with the incoming byte merged into its lane
    always_comb begin
        o_word              = r_asm;
        o_word[8*r_idx +: 8] = i_byte;
    end

    assign o_last = (r_idx == c_idx_w'(WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a byte stream, packs it into 32-bit words and writes
//                them to instruction memory, then releases the core reset.
//                Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing
//                XOR checksum word that must match before the core is run).
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] c_base_addr = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   c_max_words = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
    localparam bit c_cksum_en = 1'b1;
`else
    localparam bit c_cksum_en = 1'b0;
`endif

    state_t                r_state, w_next;
    logic [ADDR_WIDTH:0]   r_word_count, r_count, w_count_inc;
    logic [ADDR_WIDTH-1:0] r_addr, r_imem_addr;
    logic [31:0]           r_imem_wdata, w_word;
    logic                  r_done, r_error;
    logic                  w_idle_like, w_count_ok, w_start_go, w_start_bad;
    logic                  w_accept, w_pk_last, w_last, w_final_write;
    logic                  w_cksum_phase, w_cksum_ok;

    assign w_idle_like   = (r_state == IDLE) || (r_state == DONE);
    assign w_count_ok    = (word_count != '0) && (word_count <= c_max_words);
    assign w_start_go    = start && w_idle_like && w_count_ok;
    assign w_start_bad   = start && w_idle_like && !w_count_ok;
    assign w_accept      = byte_valid && (r_state == RECV);
    assign w_last        = w_accept && w_pk_last;
    assign w_count_inc   = r_count + 1'b1;
    assign w_final_write = (r_state == WRITE) && (w_count_inc == r_word_count);

    byte_packer u_packer (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_clear  (w_start_go),
        .i_accept (w_accept),
        .i_byte   (byte_data),
        .o_last   (w_pk_last),
        .o_word   (w_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic        r_cksum_phase;
    logic [31:0] r_xor;

    // Running XOR of written words; the word after the last payload is the checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cksum_phase <= 1'b0;
            r_xor         <= '0;
        end else if (w_start_go) begin
            r_cksum_phase <= 1'b0;
            r_xor         <= '0;
        end else if (r_state == WRITE) begin
            r_xor <= r_xor ^ r_imem_wdata;
            if (w_final_write) begin
                r_cksum_phase <= 1'b1;
            end
        end
    end

    assign w_cksum_phase = r_cksum_phase;
    assign w_cksum_ok    = (w_word == r_xor);
`else
    assign w_cksum_phase = 1'b0;
    assign w_cksum_ok    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        core_reset = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                core_reset = (r_state == DONE) && !r_error;
                if (w_start_go) begin
                    w_next = RECV;
                end else if (w_start_bad) begin
                    w_next = IDLE;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_last) begin
                    if (!w_cksum_phase) begin
                        w_next = WRITE;
                    end else if (w_cksum_ok) begin
                        w_next = DONE;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (!w_final_write || c_cksum_en) begin
                    w_next = RECV;
                end else begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/counter, write-port registers and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= c_base_addr;
            r_count      <= '0;
            r_word_count <= '0;
            r_imem_addr  <= c_base_addr;
            r_imem_wdata <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_start_go) begin
                r_addr       <= c_base_addr;
                r_count      <= '0;
                r_word_count <= word_count;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else if (w_start_bad) begin
                r_done  <= 1'b0;
                r_error <= 1'b1;
            end
            // Capture the completed word so the write port holds it afterwards
            if (w_last && !w_cksum_phase) begin
                r_imem_addr  <= r_addr;
                r_imem_wdata <= w_word;
            end
            if (r_state == WRITE) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= w_count_inc;
                if (w_final_write && !c_cksum_en) begin
                    r_done <= 1'b1;
                end
            end
            if (w_last && w_cksum_phase) begin
                r_done  <= w_cksum_ok;
                r_error <= !w_cksum_ok;
            end
        end
    end

    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0, is the first word address written.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 start  input  1  one-cycle request to begin a load; sampled in IDLE and DONE only.
REQ-006 word_count  input  ADDR_WIDTH+1  number of 32-bit words to load; latched on accepted start.
REQ-007 byte_valid  input  1  producer has a program byte on byte_data.
REQ-008 byte_data  input  8  program byte, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-012 imem_wdata  output  32  instruction word to write.
REQ-013 core_reset  output  1  active-low reset for the core; 0 holds the core.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load completed without error; level.
REQ-016 error  output  1  load rejected or failed; level.

Function
REQ-017 States SHALL be IDLE, RECV, WRITE, DONE.
REQ-018 IDLE/DONE + start: if word_count == 0 or word_count > 2**ADDR_WIDTH -> IDLE with error=1; else -> RECV, address=BASE_ADDR, word counter=0, done=0, error=0, core_reset=0.
REQ-019 byte_ready SHALL be 1 only in RECV; a byte transfers when byte_valid && byte_ready.
REQ-020 Byte k (0..3) of a word SHALL land in imem_wdata bits [8k+7:8k]; byte_valid low stalls without losing assembled bytes.
REQ-021 Fourth accepted byte -> WRITE next cycle; WRITE SHALL assert imem_we for exactly one cycle with the assembled word and current address.
REQ-022 After WRITE: address += 1 (modulo 2**ADDR_WIDTH), counter += 1; counter == word_count -> DONE, else -> RECV.
REQ-023 Latency: last byte accepted at edge N -> imem_we high in cycle N+1 -> done=1 and core_reset=1 from cycle N+2.
REQ-024 imem_we SHALL be 0 outside WRITE; imem_addr/imem_wdata hold their last values otherwise.
REQ-025 busy SHALL equal (state == RECV || state == WRITE).
REQ-026 start while busy SHALL be ignored.
REQ-027 core_reset SHALL be 1 only in DONE with error=0.
REQ-028 start in DONE SHALL restart the load and drive core_reset=0 from the next cycle.

Reset
REQ-029 reset=0 SHALL force IDLE, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=0, busy=0, done=0, error=0, counters and byte index 0.
REQ-030 reset asserted mid-load SHALL abandon the partial word with no further imem_we.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined: after the last payload word, one extra 4-byte checksum word is received (not written); done=1 if it equals the XOR of all payload words, else error=1 and core_reset stays 0.
REQ-032 Without LOADER_CHECKSUM_EN: no checksum word is received; DONE follows the last payload write directly.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum, WORD_BYTES=4 and NOP_INSTR=32'h00000013.
REQ-034 Sub-module byte_packer SHALL hold the byte index and the 32-bit assembly register.

Verification
REQ-035 Load 2 words 0x00500093, 0x00000013 as bytes 93 00 50 00 13 00 00 00 -> writes at addr 0 and 1, then done=1, core_reset=1.
REQ-036 byte_valid low for 3 cycles between bytes 2 and 3 -> same word written, one imem_we per word.
REQ-037 start with word_count=0 -> error=1, no imem_we, core_reset=0.
REQ-038 reset=0 after 6 bytes of a 2-word load -> 1 write only, all outputs at reset values.
REQ-039 LOADER_CHECKSUM_EN, payload 0x11111111, 0x22222222, checksum 0x33333333 -> done=1; checksum 0x33333334 -> error=1, core_reset=0.
REQ-040 start pulsed during RECV -> ignored; counter and address continue unchanged.
